insn_queue: RTL and testbench

- Decoupling buffer directly downstream of the fetch stage, upstream of decode.
- Accepts {pc, insn} pairs from fetch through a valid/ready handshake and stores them in a DEPTH-entry circular FIFO.
- Presents the oldest entry to decode through a second valid/ready handshake.
- flush_i discards all entries on a control-flow redirect, so fetch can stall or redirect without losing or duplicating instructions.

---
 rtl/insn_queue_if.sv | 48 ++++
 rtl/insn_queue.sv | 70 +++++++
 tb/tb_insn_queue.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/insn_queue_if.sv
// Fetch/decode handshake bundle for insn_queue.
// Optional predecode fields exist only with INSN_QUEUE_PREDECODE_EN defined.
interface insn_queue_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32,
  parameter int DEPTH  = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic              flush_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [AWIDTH-1:0] in_pc_i;
  logic [DWIDTH-1:0] in_insn_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [AWIDTH-1:0] out_pc_o;
  logic [DWIDTH-1:0] out_insn_o;
  logic [CW-1:0]     count_o;
`ifdef INSN_QUEUE_PREDECODE_EN
  logic [6:0] out_opcode_o;
  logic [4:0] out_rd_o;
  logic [2:0] out_funct3_o;
  logic [4:0] out_rs1_o;
  logic [4:0] out_rs2_o;
  logic [6:0] out_funct7_o;

  modport slave (
    input  flush_i, in_valid_i, in_pc_i, in_insn_i, out_ready_i,
    output in_ready_o, out_valid_o, out_pc_o, out_insn_o, count_o,
    output out_opcode_o, out_rd_o, out_funct3_o, out_rs1_o, out_rs2_o, out_funct7_o
  );
  modport master (
    output flush_i, in_valid_i, in_pc_i, in_insn_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_pc_o, out_insn_o, count_o,
    input  out_opcode_o, out_rd_o, out_funct3_o, out_rs1_o, out_rs2_o, out_funct7_o
  );
`else
  modport slave (
    input  flush_i, in_valid_i, in_pc_i, in_insn_i, out_ready_i,
    output in_ready_o, out_valid_o, out_pc_o, out_insn_o, count_o
  );
  modport master (
    output flush_i, in_valid_i, in_pc_i, in_insn_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_pc_o, out_insn_o, count_o
  );
`endif
endinterface

// File: rtl/insn_queue.sv
// Fetch-to-decode instruction FIFO (DEPTH entries, count-based full/empty, flush).
// Define INSN_QUEUE_PREDECODE_EN to add RISC-V field slices of the head instruction.
module insn_queue #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32,
  parameter int DEPTH  = 4
) (
  input  logic         clk,
  input  logic         rst,
  insn_queue_if.slave  q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [AWIDTH-1:0] pc;
    logic [DWIDTH-1:0] insn;
  } entry_t;

  entry_t        r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push, w_pop;
  entry_t        w_head;

  // Ready/valid come only from registered count, so no comb path in->out.
  assign q.in_ready_o  = (r_count != FULL);
  assign q.out_valid_o = (r_count != '0);
  assign q.count_o     = r_count;

  assign w_push = q.in_valid_i  && q.in_ready_o  && !q.flush_i;
  assign w_pop  = q.out_valid_o && q.out_ready_i && !q.flush_i;

  assign w_head       = q.out_valid_o ? r_mem[r_rd_ptr] : '0;
  assign q.out_pc_o   = w_head.pc;
  assign q.out_insn_o = w_head.insn;

`ifdef INSN_QUEUE_PREDECODE_EN
  assign q.out_opcode_o = w_head.insn[6:0];
  assign q.out_rd_o     = w_head.insn[11:7];
  assign q.out_funct3_o = w_head.insn[14:12];
  assign q.out_rs1_o    = w_head.insn[19:15];
  assign q.out_rs2_o    = w_head.insn[24:20];
  assign q.out_funct7_o = w_head.insn[31:25];
`endif

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= '{pc: q.in_pc_i, insn: q.in_insn_i};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (q.flush_i) begin
      r_count  <= '0;
      r_rd_ptr <= r_wr_ptr;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: tb/tb_insn_queue.sv
// Directed bench for insn_queue: queue-based reference model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_insn_queue;
  localparam int DW = 32, AW = 32, DEPTH = 4;

  logic clk, rst;
  int   checks = 0, errors = 0;

  insn_queue_if #(.DWIDTH(DW), .AWIDTH(AW), .DEPTH(DEPTH)) qif ();
  insn_queue #(.DWIDTH(DW), .AWIDTH(AW), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst), .q(qif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [31:0] pc);
    return pc ^ 32'h0000_0013;
  endfunction

  // Reference model: plain queue of {pc, insn}
  logic [31:0] m_pc[$], m_in[$], log_pc[$];
  bit mp, mo;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pc.delete(); m_in.delete();
    end else if (qif.flush_i) begin
      m_pc.delete(); m_in.delete();
    end else begin
      mp = qif.in_valid_i && (m_pc.size() < DEPTH);
      mo = qif.out_ready_i && (m_pc.size() > 0);
      if (mo) begin void'(m_pc.pop_front()); void'(m_in.pop_front()); end
      if (mp) begin m_pc.push_back(qif.in_pc_i); m_in.push_back(qif.in_insn_i); end
    end
  end

  logic [31:0] e_pc, e_in;
  always @(negedge clk) begin
    e_pc = (m_pc.size() != 0) ? m_pc[0] : 32'h0;
    e_in = (m_in.size() != 0) ? m_in[0] : 32'h0;
    chk("in_ready", qif.in_ready_o, m_pc.size() != DEPTH);
    chk("out_valid", qif.out_valid_o, m_pc.size() != 0);
    chk("count", qif.count_o, m_pc.size());
    chk("out_pc", qif.out_pc_o, e_pc);
    chk("out_insn", qif.out_insn_o, e_in);
`ifdef INSN_QUEUE_PREDECODE_EN
    chk("opcode", qif.out_opcode_o, e_in[6:0]);
    chk("rd", qif.out_rd_o, e_in[11:7]);
    chk("funct3", qif.out_funct3_o, e_in[14:12]);
    chk("rs1", qif.out_rs1_o, e_in[19:15]);
    chk("rs2", qif.out_rs2_o, e_in[24:20]);
    chk("funct7", qif.out_funct7_o, e_in[31:25]);
`endif
    if (rst && qif.out_valid_o && qif.out_ready_i && !qif.flush_i) log_pc.push_back(qif.out_pc_o);
  end

  task automatic cyc();
    @(posedge clk); #2;
  endtask

  task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] insn,
                       input bit rdy, input bit fl);
    qif.in_valid_i = v; qif.in_pc_i = pc; qif.in_insn_i = insn;
    qif.out_ready_i = rdy; qif.flush_i = fl;
  endtask

  initial begin
    logic [31:0] next_pc;
    bit acc, found;
    int k;
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    cyc(); cyc();
    chk("rst_valid", qif.out_valid_o, 0);
    chk("rst_ready", qif.in_ready_o, 1);
    chk("rst_count", qif.count_o, 0);
    chk("rst_pc", qif.out_pc_o, 0);
    rst = 1'b1;
    cyc();

    // single transfer
    drive(1, 32'h0100_0000, 32'h0050_0093, 0, 0); cyc();
    drive(0, 0, 0, 0, 0);
    chk("single_valid", qif.out_valid_o, 1);
    chk("single_pc", qif.out_pc_o, 32'h0100_0000);
    chk("single_insn", qif.out_insn_o, 32'h0050_0093);
    chk("single_count", qif.count_o, 1);
    drive(0, 0, 0, 1, 0); cyc();
    drive(0, 0, 0, 0, 0);
    chk("single_drained", qif.count_o, 0);

    // fill and backpressure
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h0100_0000 + 4 * i, mk(32'h0100_0000 + 4 * i), 0, 0); cyc();
    end
    drive(1, 32'h0100_0010, mk(32'h0100_0010), 0, 0);
    repeat (3) cyc();
    chk("full_count", qif.count_o, 4);
    chk("full_ready", qif.in_ready_o, 0);
    chk("full_head", qif.out_pc_o, 32'h0100_0000);

    // drain with wrap, 10 sequential pcs
    log_pc.delete();
    next_pc = 32'h0100_0010;
    k = 0;
    while (log_pc.size() < 10 && k < 200) begin
      drive(next_pc <= 32'h0100_0024, next_pc, mk(next_pc), (k % 3) != 2, 0);
      acc = qif.in_valid_i && qif.in_ready_o;
      cyc();
      if (acc) next_pc += 4;
      k++;
    end
    drive(0, 0, 0, 0, 0);
    chk("drain_len", log_pc.size(), 10);
    for (int i = 0; i < 10 && i < log_pc.size(); i++)
      chk("drain_seq", log_pc[i], 32'h0100_0000 + 4 * i);
    chk("drain_empty", qif.count_o, 0);

    // simultaneous push and pop at count 2
    drive(1, 32'h0100_0028, mk(32'h0100_0028), 0, 0); cyc();
    drive(1, 32'h0100_002C, mk(32'h0100_002C), 0, 0); cyc();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h0100_0030 + 4 * i, mk(32'h0100_0030 + 4 * i), 1, 0); cyc();
      chk("simul_count", qif.count_o, 2);
      chk("simul_head", qif.out_pc_o, 32'h0100_002C + 4 * i);
    end
    drive(1, 32'h0100_003C, mk(32'h0100_003C), 0, 0); cyc();
    chk("pre_flush_count", qif.count_o, 3);

    // flush beats concurrent push and pop
    drive(1, 32'h0100_0040, mk(32'h0100_0040), 1, 1); cyc();
    drive(0, 0, 0, 0, 0);
    chk("flush_count", qif.count_o, 0);
    chk("flush_valid", qif.out_valid_o, 0);
    drive(1, 32'h0100_0080, 32'h0050_0093, 0, 0); cyc();
    drive(1, 32'h0100_0084, mk(32'h0100_0084), 0, 0); cyc();
    drive(0, 0, 0, 0, 0);
    chk("post_flush_head", qif.out_pc_o, 32'h0100_0080);
    chk("post_flush_count", qif.count_o, 2);
    found = 0;
    foreach (log_pc[i]) if (log_pc[i] == 32'h0100_0040) found = 1;
    chk("flush_no_0x40", found, 0);
`ifdef INSN_QUEUE_PREDECODE_EN
    chk("pd_opcode", qif.out_opcode_o, 7'h13);
    chk("pd_rd", qif.out_rd_o, 5'd1);
    chk("pd_rs1", qif.out_rs1_o, 5'd0);
`endif

    // asynchronous reset between edges
    #1 rst = 1'b0;
    #1;
    chk("arst_valid", qif.out_valid_o, 0);
    chk("arst_count", qif.count_o, 0);
    chk("arst_ready", qif.in_ready_o, 1);
    chk("arst_pc", qif.out_pc_o, 0);
    cyc();
    rst = 1'b1;
    cyc();
    drive(1, 32'h0100_0100, mk(32'h0100_0100), 0, 0); cyc();
    drive(0, 0, 0, 0, 0);
    chk("after_rst_head", qif.out_pc_o, 32'h0100_0100);
    chk("after_rst_count", qif.count_o, 1);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
